l2_port_arbiter: RTL and testbench
==================================

# l2_port_arbiter

- Two-requester arbiter that shares the single L2 cache request port between the instruction-side L1 (requester 0) and the data-side L1 (requester 1).
- Sits between the L1 controllers and L2 in the cache system, replacing the direct single-CPU connection to L2.
- Selects a winner round-robin, holds one transaction outstanding at a time, and forwards the L2 read data and completion back to the winner.
- Optionally keeps per-requester grant and contention counters.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CNT_W, 32, statistics counter width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- rq0_req / rq1_req  in  1  request, held until grant
- rq0_write / rq1_write  in  1  1 = write, 0 = read
- rq0_addr / rq1_addr  in  ADDR_W  request address
- rq0_wdata / rq1_wdata  in  DATA_W  write data
- rq0_gnt / rq1_gnt  out  1  one-cycle grant pulse
- rq0_done / rq1_done  out  1  one-cycle completion pulse
- rq_rdata  out  DATA_W  read data, valid with rqN_done
- l2_req  out  1  one-cycle request to L2
- l2_write  out  1  write qualifier
- l2_addr  out  ADDR_W  address to L2
- l2_wdata  out  DATA_W  write data to L2
- l2_done  in  1  L2 completion pulse
- l2_rdata  in  DATA_W  L2 read data, valid with l2_done
- rq0_grant_count / rq1_grant_count  out  CNT_W  grants issued per requester
- contention_count  out  CNT_W  arbitration cycles where both requested

## Operation
- FSM: IDLE, ISSUE, WAIT.
- **IDLE**
  - If exactly one rqN_req is high, that requester wins.
  - If both are high, the winner is the requester indicated by the priority pointer `last_ptr`.
  - On a win, latch the winner id, write, addr and wdata, then go to ISSUE.
- **ISSUE** (one cycle)
  - l2_req=1, rqN_gnt=1 for the winner; l2_write/l2_addr/l2_wdata are driven from the latched values.
  - Next state is WAIT.
- **WAIT**
  - On l2_done: register l2_rdata into rq_rdata, pulse rqN_done for the winner next cycle, return to IDLE.
  - On that same edge, `last_ptr` points to the non-winner.
- Priority pointer: `last_ptr` resets to 0, so requester 0 wins the first tie. It updates only on completion.
- l2_addr/l2_wdata/l2_write hold the latched values through WAIT; they are 0 in IDLE.
- rq_rdata holds its last value until the next completion; writes also capture l2_rdata.
- Requester protocol:
  - Hold req and payload stable until gnt.
  - Deassert req in the gnt cycle.
  - A new request from the same requester is legal from the rqN_done cycle onward.
- Boundary conditions:
  - l2_done while in IDLE or ISSUE: ignored.
  - req arriving during ISSUE/WAIT: waits and is arbitrated in IDLE.
  - Reset mid-transaction: the FSM goes to IDLE and the in-flight transaction is dropped with no done pulse. A late l2_done after that is ignored.
- Reset values: all outputs 0, counters 0, `last_ptr`=0, state IDLE.

## Timing
- Request in cycle 0 (IDLE) -> gnt and l2_req in cycle 1 -> l2_done in cycle 1+k, k≥1 -> rqN_done and rq_rdata in cycle 2+k.
- Minimum latency is 3 cycles.
- Throughput: one transaction per 3+ cycles. Back-to-back transactions always pass through IDLE.
- rqN_gnt and l2_req are registered, coincident and exactly one cycle wide.
- At most one rqN_gnt and one rqN_done are high in any cycle.

## Configuration
- Macro `L2_ARB_STATS_EN`.
- With `L2_ARB_STATS_EN` defined:
  - rqN_grant_count increments in each ISSUE cycle of that requester.
  - contention_count increments in each IDLE cycle where both reqs are high.
  - All counters saturate at 2^CNT_W−1 and clear on reset.
- Without it: the counter ports remain and are tied to 0; no counter logic is built.

## Structure
- Package `l2_arb_pkg`:
  - state enum {IDLE, ISSUE, WAIT}
  - requester id constants RQ0=0, RQ1=1
  - default widths
- Sub-module `l2_arb_stats`: saturating counters, instantiated only under `L2_ARB_STATS_EN`.
- FSM, payload latch and `last_ptr` live in the top module.

## Test plan
- **Single read, rq0:** rq0 reads 0x0000_0100, L2 returns 0xA000_0100 with k=1. Expect gnt0 at cycle 1, l2_addr=0x100 with l2_write=0, done0 at cycle 3, rq_rdata=0xA000_0100.
- **Simultaneous after reset:** rq0 and rq1 both request. rq0 is granted first, then rq1 in the next IDLE. Expect done0 before done1, and contention_count=1 with stats enabled.
- **Sustained contention:** both requesters request continuously for 6 transactions. Grants alternate 0,1,0,1,0,1; rq0_grant_count=3 and rq1_grant_count=3.
- **Write forwarding:** rq1 writes 0xDEADBEEF to 0x0000_0200, L2 latency k=4. Expect l2_wdata=0xDEADBEEF and l2_write=1 held through WAIT, done1 at cycle 6.
- **Spurious completion:** l2_done asserted in IDLE and in the ISSUE cycle. No done pulse and no state change; the transaction completes only on the later l2_done in WAIT.
- **Reset mid-transaction:** reset asserted in WAIT, then l2_done one cycle after reset is released. No rqN_done, all outputs 0, the next tie goes to rq0.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// Shared types, requester ids and default widths for the L2 port arbiter.
// The optional statistics block is enabled by defining L2_ARB_STATS_EN.
package l2_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic RQ0 = 1'b0;
  localparam logic RQ1 = 1'b1;

  // A lone requester always wins; on a tie the priority pointer decides.
  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic last_ptr);
    logic win;
    win = last_ptr;
    if (req0 && !req1) win = RQ0;
    else if (req1 && !req0) win = RQ1;
    return win;
  endfunction

endpackage

// File: rtl/l2_arb_stats.sv
// Saturating grant and contention counters for the L2 port arbiter.
// Only instantiated when L2_ARB_STATS_EN is defined.
module l2_arb_stats
  import l2_arb_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             grant0_inc,
  input  logic             grant1_inc,
  input  logic             contention_inc,
  output logic [CNT_W-1:0] rq0_grant_count,
  output logic [CNT_W-1:0] rq1_grant_count,
  output logic [CNT_W-1:0] contention_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] grant0_q, grant0_d;
  logic [CNT_W-1:0] grant1_q, grant1_d;
  logic [CNT_W-1:0] cont_q, cont_d;

  always_comb begin
    grant0_d = grant0_q;
    grant1_d = grant1_q;
    cont_d   = cont_q;
    if (grant0_inc && (grant0_q != CNT_MAX)) grant0_d = grant0_q + CNT_W'(1);
    if (grant1_inc && (grant1_q != CNT_MAX)) grant1_d = grant1_q + CNT_W'(1);
    if (contention_inc && (cont_q != CNT_MAX)) cont_d = cont_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant0_q <= '0;
      grant1_q <= '0;
      cont_q   <= '0;
    end else begin
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      cont_q   <= cont_d;
    end
  end

  assign rq0_grant_count  = grant0_q;
  assign rq1_grant_count  = grant1_q;
  assign contention_count = cont_q;

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 request port between the I-side and D-side L1s.
// Define L2_ARB_STATS_EN to build the per-requester grant/contention counters.
module l2_port_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rq0_req,
  input  logic              rq0_write,
  input  logic [ADDR_W-1:0] rq0_addr,
  input  logic [DATA_W-1:0] rq0_wdata,
  input  logic              rq1_req,
  input  logic              rq1_write,
  input  logic [ADDR_W-1:0] rq1_addr,
  input  logic [DATA_W-1:0] rq1_wdata,
  output logic              rq0_gnt,
  output logic              rq1_gnt,
  output logic              rq0_done,
  output logic              rq1_done,
  output logic [DATA_W-1:0] rq_rdata,
  output logic              l2_req,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [DATA_W-1:0] l2_wdata,
  input  logic              l2_done,
  input  logic [DATA_W-1:0] l2_rdata,
  output logic [CNT_W-1:0]  rq0_grant_count,
  output logic [CNT_W-1:0]  rq1_grant_count,
  output logic [CNT_W-1:0]  contention_count
);

  state_e            state_q, state_d;
  logic              win_q, win_d;
  logic              last_ptr_q, last_ptr_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              l2_req_q, l2_req_d;

  // Next-state and registered-output logic; payload regs double as the L2 bus
  // and are zeroed whenever the FSM is back in IDLE.
  always_comb begin
    state_d    = state_q;
    win_d      = win_q;
    last_ptr_d = last_ptr_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    l2_req_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rq0_req || rq1_req) begin
          win_d    = pick_winner(rq0_req, rq1_req, last_ptr_q);
          write_d  = (win_d == RQ1) ? rq1_write : rq0_write;
          addr_d   = (win_d == RQ1) ? rq1_addr  : rq0_addr;
          wdata_d  = (win_d == RQ1) ? rq1_wdata : rq0_wdata;
          gnt0_d   = (win_d == RQ0);
          gnt1_d   = (win_d == RQ1);
          l2_req_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (l2_done) begin
          rdata_d    = l2_rdata;
          done0_d    = (win_q == RQ0);
          done1_d    = (win_q == RQ1);
          last_ptr_d = ~win_q;
          write_d    = 1'b0;
          addr_d     = '0;
          wdata_d    = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      win_q      <= RQ0;
      last_ptr_q <= RQ0;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      l2_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      last_ptr_q <= last_ptr_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      l2_req_q   <= l2_req_d;
    end
  end

  assign rq0_gnt  = gnt0_q;
  assign rq1_gnt  = gnt1_q;
  assign rq0_done = done0_q;
  assign rq1_done = done1_q;
  assign rq_rdata = rdata_q;
  assign l2_req   = l2_req_q;
  assign l2_write = write_q;
  assign l2_addr  = addr_q;
  assign l2_wdata = wdata_q;

`ifdef L2_ARB_STATS_EN
  logic contention_inc_c;

  // A tie is only arbitrated (and counted) in IDLE.
  assign contention_inc_c = (state_q == IDLE) && rq0_req && rq1_req;

  l2_arb_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk             (clk),
    .reset           (reset),
    .grant0_inc      (gnt0_q),
    .grant1_inc      (gnt1_q),
    .contention_inc  (contention_inc_c),
    .rq0_grant_count (rq0_grant_count),
    .rq1_grant_count (rq1_grant_count),
    .contention_count(contention_count)
  );
`else
  assign rq0_grant_count  = '0;
  assign rq1_grant_count  = '0;
  assign contention_count = '0;
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level model. Counter expectations follow L2_ARB_STATS_EN.
module tb_l2_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;
`ifdef L2_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rq0_req, rq0_write, rq1_req, rq1_write;
  logic [AW-1:0] rq0_addr, rq1_addr;
  logic [DW-1:0] rq0_wdata, rq1_wdata;
  logic          rq0_gnt, rq1_gnt, rq0_done, rq1_done;
  logic [DW-1:0] rq_rdata;
  logic          l2_req, l2_write, l2_done;
  logic [AW-1:0] l2_addr;
  logic [DW-1:0] l2_wdata, l2_rdata;
  logic [CW-1:0] rq0_grant_count, rq1_grant_count, contention_count;
  logic [197:0]  all_outs;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign all_outs = {rq0_gnt, rq1_gnt, rq0_done, rq1_done, l2_req, l2_write,
                     l2_addr, l2_wdata, rq_rdata,
                     rq0_grant_count, rq1_grant_count, contention_count};

  l2_port_arbiter dut (
    .clk(clk), .reset(reset),
    .rq0_req(rq0_req), .rq0_write(rq0_write), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq1_req(rq1_req), .rq1_write(rq1_write), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq0_gnt(rq0_gnt), .rq1_gnt(rq1_gnt), .rq0_done(rq0_done), .rq1_done(rq1_done),
    .rq_rdata(rq_rdata), .l2_req(l2_req), .l2_write(l2_write), .l2_addr(l2_addr),
    .l2_wdata(l2_wdata), .l2_done(l2_done), .l2_rdata(l2_rdata),
    .rq0_grant_count(rq0_grant_count), .rq1_grant_count(rq1_grant_count),
    .contention_count(contention_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rq0_req = 1'b0; rq0_write = 1'b0; rq0_addr = '0; rq0_wdata = '0;
    rq1_req = 1'b0; rq1_write = 1'b0; rq1_addr = '0; rq1_wdata = '0;
    l2_done = 1'b0; l2_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if (all_outs !== '0) $display("FAIL reset_outputs: got %h exp 0", all_outs);
    else n_pass++;
  endtask

  task automatic test_single_read();
    do_reset();
    rq0_req = 1'b1; rq0_write = 1'b0; rq0_addr = 32'h0000_0100;
    step();
    n_chk++;
    if ({rq0_gnt, rq1_gnt, l2_req} !== 3'b101)
      $display("FAIL rd_grant: got %b exp 101", {rq0_gnt, rq1_gnt, l2_req});
    else n_pass++;
    n_chk++;
    if ({l2_write, l2_addr} !== {1'b0, 32'h0000_0100})
      $display("FAIL rd_l2_bus: got w=%b a=%h exp w=0 a=00000100", l2_write, l2_addr);
    else n_pass++;
    rq0_req = 1'b0;
    step();
    l2_done = 1'b1; l2_rdata = 32'hA000_0100;
    step();
    l2_done = 1'b0;
    n_chk++;
    if ({rq0_done, rq1_done, rq_rdata} !== {2'b10, 32'hA000_0100})
      $display("FAIL rd_done: got d=%b data=%h exp d=10 data=a0000100",
               {rq0_done, rq1_done}, rq_rdata);
    else n_pass++;
    step();
    n_chk++;
    if ({rq0_done, l2_addr, rq_rdata} !== {1'b0, 32'h0, 32'hA000_0100})
      $display("FAIL rd_after: got d=%b a=%h data=%h exp d=0 a=0 data=a0000100",
               rq0_done, l2_addr, rq_rdata);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    rq0_req = 1'b1; rq0_addr = 32'h10;
    rq1_req = 1'b1; rq1_addr = 32'h20;
    step();
    n_chk++;
    if ({rq0_gnt, rq1_gnt, l2_addr} !== {2'b10, 32'h10})
      $display("FAIL tie_first: got g=%b a=%h exp g=10 a=10", {rq0_gnt, rq1_gnt}, l2_addr);
    else n_pass++;
    rq0_req = 1'b0;
    step();
    l2_done = 1'b1; l2_rdata = 32'h1111_0000;
    step();
    l2_done = 1'b0;
    n_chk++;
    if ({rq0_done, rq1_done} !== 2'b10)
      $display("FAIL tie_done0: got %b exp 10", {rq0_done, rq1_done});
    else n_pass++;
    step();
    n_chk++;
    if ({rq0_gnt, rq1_gnt, l2_addr} !== {2'b01, 32'h20})
      $display("FAIL tie_second: got g=%b a=%h exp g=01 a=20", {rq0_gnt, rq1_gnt}, l2_addr);
    else n_pass++;
    rq1_req = 1'b0;
    step();
    l2_done = 1'b1; l2_rdata = 32'h2222_0000;
    step();
    l2_done = 1'b0;
    n_chk++;
    if ({rq0_done, rq1_done, rq_rdata} !== {2'b01, 32'h2222_0000})
      $display("FAIL tie_done1: got d=%b data=%h exp d=01 data=22220000",
               {rq0_done, rq1_done}, rq_rdata);
    else n_pass++;
    n_chk++;
    if ({rq0_grant_count, rq1_grant_count, contention_count} !==
        {CW'(STATS ? 1 : 0), CW'(STATS ? 1 : 0), CW'(STATS ? 1 : 0)})
      $display("FAIL tie_counters: got %0d/%0d/%0d exp %0d each",
               rq0_grant_count, rq1_grant_count, contention_count, STATS ? 1 : 0);
    else n_pass++;
  endtask

  task automatic test_sustained();
    int got;
    int n_rr = 0;
    do_reset();
    rq0_req = 1'b1; rq0_addr = 32'h1000;
    rq1_req = 1'b1; rq1_addr = 32'h2000;
    for (int i = 0; i < 6; i++) begin
      step();
      for (int t = 0; t < 8 && !(rq0_gnt || rq1_gnt); t++) step();
      got = rq1_gnt ? 1 : (rq0_gnt ? 0 : -1);
      n_chk++;
      if (got !== (i % 2)) $display("FAIL sustained_grant%0d: got %0d exp %0d", i, got, i % 2);
      else n_pass++;
      if (got < 0) break;
      if (got == 0) rq0_req = 1'b0; else rq1_req = 1'b0;
      step();
      l2_done = 1'b1; l2_rdata = DW'(i);
      step();
      l2_done = 1'b0;
      if (i < 4) begin
        if (got == 0) rq0_req = 1'b1; else rq1_req = 1'b1;
        n_rr++;
      end
    end
    step();
    n_chk++;
    if ({rq0_grant_count, rq1_grant_count, contention_count} !==
        {CW'(STATS ? 3 : 0), CW'(STATS ? 3 : 0), CW'(STATS ? 1 + n_rr : 0)})
      $display("FAIL sustained_counters: got %0d/%0d/%0d exp %0d/%0d/%0d",
               rq0_grant_count, rq1_grant_count, contention_count,
               STATS ? 3 : 0, STATS ? 3 : 0, STATS ? 1 + n_rr : 0);
    else n_pass++;
  endtask

  task automatic test_write();
    do_reset();
    rq1_req = 1'b1; rq1_write = 1'b1; rq1_addr = 32'h0000_0200; rq1_wdata = 32'hDEAD_BEEF;
    step();
    n_chk++;
    if ({rq0_gnt, rq1_gnt, l2_req} !== 3'b011)
      $display("FAIL wr_grant: got %b exp 011", {rq0_gnt, rq1_gnt, l2_req});
    else n_pass++;
    rq1_req = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      n_chk++;
      if ({l2_write, l2_addr, l2_wdata, rq0_done, rq1_done} !==
          {1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 2'b00})
        $display("FAIL wr_hold_c%0d: got w=%b a=%h d=%h done=%b exp w=1 a=200 d=deadbeef done=00",
                 c, l2_write, l2_addr, l2_wdata, {rq0_done, rq1_done});
      else n_pass++;
      if (c == 5) begin
        l2_done = 1'b1; l2_rdata = 32'h0BAD_F00D;
      end
      step();
    end
    l2_done = 1'b0;
    n_chk++;
    if ({rq0_done, rq1_done, rq_rdata, l2_write} !== {2'b01, 32'h0BAD_F00D, 1'b0})
      $display("FAIL wr_done: got d=%b data=%h w=%b exp d=01 data=0badf00d w=0",
               {rq0_done, rq1_done}, rq_rdata, l2_write);
    else n_pass++;
  endtask

  task automatic test_spurious();
    do_reset();
    l2_done = 1'b1; l2_rdata = 32'h5555_5555;
    step();
    l2_done = 1'b0;
    n_chk++;
    if ({rq0_done, rq1_done, l2_req, rq_rdata} !== {3'b000, 32'h0})
      $display("FAIL spur_idle: got d=%b req=%b data=%h exp all 0",
               {rq0_done, rq1_done}, l2_req, rq_rdata);
    else n_pass++;
    rq0_req = 1'b1; rq0_addr = 32'h300;
    step();
    rq0_req = 1'b0;
    l2_done = 1'b1; l2_rdata = 32'h6666_6666;
    step();
    l2_done = 1'b0;
    step();
    n_chk++;
    if ({rq0_done, rq1_done, l2_addr, rq_rdata} !== {2'b00, 32'h300, 32'h0})
      $display("FAIL spur_issue: got d=%b a=%h data=%h exp d=00 a=300 data=0",
               {rq0_done, rq1_done}, l2_addr, rq_rdata);
    else n_pass++;
    l2_done = 1'b1; l2_rdata = 32'h7777_7777;
    step();
    l2_done = 1'b0;
    n_chk++;
    if ({rq0_done, rq1_done, rq_rdata} !== {2'b10, 32'h7777_7777})
      $display("FAIL spur_complete: got d=%b data=%h exp d=10 data=77777777",
               {rq0_done, rq1_done}, rq_rdata);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rq1_req = 1'b1; rq1_addr = 32'h400;
    step();
    rq1_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_chk++;
    if (all_outs !== '0) $display("FAIL rstmid_outputs: got %h exp 0", all_outs);
    else n_pass++;
    step();
    l2_done = 1'b1; l2_rdata = 32'h8888_8888;
    step();
    l2_done = 1'b0;
    n_chk++;
    if (all_outs !== '0) $display("FAIL rstmid_late_done: got %h exp 0", all_outs);
    else n_pass++;
    rq0_req = 1'b1; rq0_addr = 32'h500;
    rq1_req = 1'b1; rq1_addr = 32'h600;
    step();
    n_chk++;
    if ({rq0_gnt, rq1_gnt, l2_addr} !== {2'b10, 32'h500})
      $display("FAIL rstmid_tie: got g=%b a=%h exp g=10 a=500", {rq0_gnt, rq1_gnt}, l2_addr);
    else n_pass++;
    idle_inputs();
  endtask

  // Transaction-level model: one outstanding transfer, pointer flips to the
  // loser on each completion, cycle timestamps give expected pulse positions.
  task automatic test_random();
    int ptr = 0, busy = 0, win = 0, done_win = 0;
    int gnt_at = -1, l2d_at = -1, done_at = -1;
    int g0 = 0, g1 = 0, cont = 0;
    int outst0 = 0, outst1 = 0;
    logic [DW-1:0] exp_rdata = '0, pend_data = '0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0;
    logic          p_write = 1'b0;
    logic [1:0]    e_g, e_d;
    logic [64:0]   e_bus;
    do_reset();
    for (int cyc = 0; cyc < 420; cyc++) begin
      if (cyc == done_at) begin
        busy = 0;
        ptr = 1 - done_win;
        exp_rdata = pend_data;
        if (done_win == 0) outst0 = 0; else outst1 = 0;
      end
      e_g = (cyc == gnt_at) ? ((win == 0) ? 2'b10 : 2'b01) : 2'b00;
      e_d = (cyc == done_at) ? ((done_win == 0) ? 2'b10 : 2'b01) : 2'b00;
      e_bus = busy ? {p_write, p_addr, p_wdata} : 65'd0;
      n_chk++;
      if ({rq0_gnt, rq1_gnt, l2_req} !== {e_g, |e_g})
        $display("FAIL rnd_grant@%0d: got %b exp %b", cyc, {rq0_gnt, rq1_gnt, l2_req}, {e_g, |e_g});
      else n_pass++;
      n_chk++;
      if ({rq0_done, rq1_done, rq_rdata} !== {e_d, exp_rdata})
        $display("FAIL rnd_done@%0d: got d=%b data=%h exp d=%b data=%h",
                 cyc, {rq0_done, rq1_done}, rq_rdata, e_d, exp_rdata);
      else n_pass++;
      n_chk++;
      if ({l2_write, l2_addr, l2_wdata} !== e_bus)
        $display("FAIL rnd_bus@%0d: got %h exp %h", cyc, {l2_write, l2_addr, l2_wdata}, e_bus);
      else n_pass++;

      if (cyc == gnt_at) begin
        if (win == 0) rq0_req = 1'b0; else rq1_req = 1'b0;
      end
      l2_done = 1'b0;
      if (busy != 0 && cyc == l2d_at) begin
        l2_done = 1'b1; l2_rdata = $urandom;
        pend_data = l2_rdata; done_at = cyc + 1; done_win = win;
      end else if ((busy == 0 || cyc == gnt_at) && $urandom_range(3) == 0) begin
        l2_done = 1'b1; l2_rdata = $urandom;
      end
      if (cyc < 400) begin
        if (!rq0_req && outst0 == 0 && $urandom_range(2) == 0) begin
          rq0_req = 1'b1; rq0_write = 1'($urandom_range(1));
          rq0_addr = $urandom; rq0_wdata = $urandom;
        end
        if (!rq1_req && outst1 == 0 && $urandom_range(2) == 0) begin
          rq1_req = 1'b1; rq1_write = 1'($urandom_range(1));
          rq1_addr = $urandom; rq1_wdata = $urandom;
        end
      end
      if (busy == 0 && (rq0_req || rq1_req)) begin
        win = (rq0_req && rq1_req) ? ptr : (rq1_req ? 1 : 0);
        if (rq0_req && rq1_req) cont++;
        if (win == 0) begin
          g0++; outst0 = 1;
          p_write = rq0_write; p_addr = rq0_addr; p_wdata = rq0_wdata;
        end else begin
          g1++; outst1 = 1;
          p_write = rq1_write; p_addr = rq1_addr; p_wdata = rq1_wdata;
        end
        busy = 1; gnt_at = cyc + 1; l2d_at = cyc + 1 + int'($urandom_range(1, 4));
      end
      step();
    end
    n_chk++;
    if ({rq0_grant_count, rq1_grant_count, contention_count} !==
        {CW'(STATS ? g0 : 0), CW'(STATS ? g1 : 0), CW'(STATS ? cont : 0)})
      $display("FAIL rnd_counters: got %0d/%0d/%0d exp %0d/%0d/%0d",
               rq0_grant_count, rq1_grant_count, contention_count,
               STATS ? g0 : 0, STATS ? g1 : 0, STATS ? cont : 0);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_sustained();
    test_write();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
